// File: rtl/layer2_argmax_pkg.sv
// Shared types and constants for the layer-2 argmax classifier.
// Optional confidence outputs are built when ARGMAX_CONF_EN is defined.
package layer2_argmax_pkg;

  localparam int unsigned DEFAULT_DATA_W      = 8;
  localparam int unsigned DEFAULT_CONF_THRESH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Index width for a class count; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer2_argmax_cmp.sv
// Combinational compare-and-update cell, time-multiplexed by the scan FSM.
// Second-best tracking exists only when ARGMAX_CONF_EN is defined.
module argmax_cmp #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [DATA_W-1:0] best,
  input  logic [IDX_W-1:0]  best_idx,
`ifdef ARGMAX_CONF_EN
  input  logic [DATA_W-1:0] second,
`endif
  input  logic [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]  cand_idx,
  output logic [DATA_W-1:0] next_best,
  output logic [IDX_W-1:0]  next_best_idx
`ifdef ARGMAX_CONF_EN
  ,
  output logic [DATA_W-1:0] next_second
`endif
);

  // Strictly greater wins, so ties keep the lower index.
  always_comb begin
    next_best     = best;
    next_best_idx = best_idx;
    if (cand > best) begin
      next_best     = cand;
      next_best_idx = cand_idx;
    end
  end

`ifdef ARGMAX_CONF_EN
  always_comb begin
    next_second = second;
    if (cand > best) begin
      next_second = best;
    end else if (cand > second) begin
      next_second = cand;
    end
  end
`endif

endmodule

// File: rtl/layer2_argmax.sv
// Output-stage argmax: captures a frame, scans one slot per clock, holds the winner.
// Define ARGMAX_CONF_EN to add the margin/low_conf confidence outputs.
module layer2_argmax
  import layer2_argmax_pkg::*;
#(
  parameter int unsigned NUM_IN      = 5,
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
`ifdef ARGMAX_CONF_EN
  parameter int unsigned CONF_THRESH = DEFAULT_CONF_THRESH,
`endif
  localparam int unsigned IDX_W      = idx_w(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] n_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         class_idx,
  output logic [DATA_W-1:0]        class_score
`ifdef ARGMAX_CONF_EN
  ,
  output logic [DATA_W-1:0]        margin,
  output logic                     low_conf
`endif
);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   frame    [NUM_IN];
  logic [DATA_W-1:0]   frame_nx [NUM_IN];
  logic [IDX_W-1:0]    scan_idx, scan_idx_nx;
  logic [DATA_W-1:0]   best, best_nx;
  logic [IDX_W-1:0]    best_idx, best_idx_nx;
  logic                out_valid_nx;
  logic [IDX_W-1:0]    class_idx_nx;
  logic [DATA_W-1:0]   class_score_nx;
  logic [DATA_W-1:0]   cmp_best;
  logic [IDX_W-1:0]    cmp_best_idx;
  logic                last;
`ifdef ARGMAX_CONF_EN
  logic [DATA_W-1:0]   second, second_nx, cmp_second;
  logic [DATA_W-1:0]   margin_nx;
  logic                low_conf_nx;
`endif

  assign in_ready = (state == IDLE) && !reset;
  assign last     = (scan_idx == IDX_W'(NUM_IN - 1));

  argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .best          (best),
    .best_idx      (best_idx),
`ifdef ARGMAX_CONF_EN
    .second        (second),
`endif
    .cand          (frame[scan_idx]),
    .cand_idx      (scan_idx),
    .next_best     (cmp_best),
    .next_best_idx (cmp_best_idx)
`ifdef ARGMAX_CONF_EN
    ,
    .next_second   (cmp_second)
`endif
  );

  // Next-state and datapath update.
  always_comb begin
    state_nx       = state;
    frame_nx       = frame;
    scan_idx_nx    = scan_idx;
    best_nx        = best;
    best_idx_nx    = best_idx;
    out_valid_nx   = out_valid;
    class_idx_nx   = class_idx;
    class_score_nx = class_score;
`ifdef ARGMAX_CONF_EN
    second_nx      = second;
    margin_nx      = margin;
    low_conf_nx    = low_conf;
`endif
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < NUM_IN; k++) begin
            frame_nx[k] = n_in[k*DATA_W +: DATA_W];
          end
          best_nx     = n_in[DATA_W-1:0];
          best_idx_nx = '0;
          scan_idx_nx = IDX_W'(1);
`ifdef ARGMAX_CONF_EN
          second_nx   = '0;
`endif
          state_nx    = SCAN;
        end
      end
      SCAN: begin
        best_nx     = cmp_best;
        best_idx_nx = cmp_best_idx;
`ifdef ARGMAX_CONF_EN
        second_nx   = cmp_second;
`endif
        if (last) begin
          out_valid_nx   = 1'b1;
          class_idx_nx   = cmp_best_idx;
          class_score_nx = cmp_best;
`ifdef ARGMAX_CONF_EN
          margin_nx      = cmp_best - cmp_second;
          low_conf_nx    = (32'(margin_nx) < CONF_THRESH);
`endif
          state_nx       = DONE;
        end else begin
          scan_idx_nx = scan_idx + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      frame       <= '{default: '0};
      scan_idx    <= '0;
      best        <= '0;
      best_idx    <= '0;
      out_valid   <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
`ifdef ARGMAX_CONF_EN
      second      <= '0;
      margin      <= '0;
      low_conf    <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      frame       <= frame_nx;
      scan_idx    <= scan_idx_nx;
      best        <= best_nx;
      best_idx    <= best_idx_nx;
      out_valid   <= out_valid_nx;
      class_idx   <= class_idx_nx;
      class_score <= class_score_nx;
`ifdef ARGMAX_CONF_EN
      second      <= second_nx;
      margin      <= margin_nx;
      low_conf    <= low_conf_nx;
`endif
    end
  end

endmodule

// File: tb/tb_layer2_argmax.sv
// Scoreboard bench for layer2_argmax: directed frames plus randomized traffic with backpressure.
module tb_layer2_argmax;

  localparam int unsigned NUM_IN = 5;
  localparam int unsigned DW     = 8;
  localparam int unsigned FW     = NUM_IN * DW;
  localparam int          THRESH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] n_in;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    class_idx;
  logic [DW-1:0] class_score;
`ifdef ARGMAX_CONF_EN
  logic [DW-1:0] margin;
  logic          low_conf;
`endif

  layer2_argmax #(.NUM_IN(NUM_IN), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .n_in        (n_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .class_idx   (class_idx),
    .class_score (class_score)
`ifdef ARGMAX_CONF_EN
    ,
    .margin      (margin),
    .low_conf    (low_conf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int score;
    int mrg;
    int low;
    int acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rand_rdy = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: max value, first slot holding it, and gap to the next largest value in the multiset.
  function automatic exp_t model(input logic [FW-1:0] f, input int acc);
    exp_t e;
    int   v[NUM_IN];
    int   mx, sec, idx;
    for (int k = 0; k < NUM_IN; k++) v[k] = int'(f[k*DW +: DW]);
    mx = 0;
    foreach (v[k]) if (v[k] > mx) mx = v[k];
    idx = -1;
    foreach (v[k]) if (idx < 0 && v[k] == mx) idx = k;
    sec = 0;
    foreach (v[k]) if (k != idx && v[k] > sec) sec = v[k];
    e.idx   = idx;
    e.score = mx;
    e.mrg   = mx - sec;
    e.low   = (mx - sec) < THRESH ? 1 : 0;
    e.acc   = acc;
    return e;
  endfunction

  function automatic logic [FW-1:0] mk(input int a0, a1, a2, a3, a4);
    return {8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [FW-1:0] f);
    int g = 0;
    n_in     = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      tick();
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      sb_q.push_back(model(f, cyc + 1));
    end
    tick();
    in_valid = 1'b0;
    n_in     = FW'({$urandom(), $urandom()});
  endtask

  task automatic drain();
    int g = 0;
    while ((sb_q.size() != 0 || out_valid) && g < 500) begin
      tick();
      g++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: latency on rise, hold under backpressure, compare on handshake.
  initial begin
    bit            pv = 1'b0, pr = 1'b0;
    logic [2:0]    pidx = '0;
    logic [DW-1:0] pscore = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (out_valid) begin
          check("in_ready_busy", 32'(in_ready), 32'd0);
          if (!pv) begin
            check("out_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("latency", 32'(cyc - sb_q[0].acc), 32'(NUM_IN - 1));
          end
        end
        if (pv && !pr) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_idx", 32'(class_idx), 32'(pidx));
          check("hold_score", 32'(class_score), 32'(pscore));
        end
        if (out_valid && out_ready && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("class_idx", 32'(class_idx), 32'(e.idx));
          check("class_score", 32'(class_score), 32'(e.score));
`ifdef ARGMAX_CONF_EN
          check("margin", 32'(margin), 32'(e.mrg));
          check("low_conf", 32'(low_conf), 32'(e.low));
`endif
        end
        pv     = out_valid;
        pr     = out_ready;
        pidx   = class_idx;
        pscore = class_score;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic [FW-1:0] f;
    reset     = 1'b1;
    in_valid  = 1'b0;
    n_in      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_idx", 32'(class_idx), 32'd0);
    check("rst_score", 32'(class_score), 32'd0);
`ifdef ARGMAX_CONF_EN
    check("rst_margin", 32'(margin), 32'd0);
    check("rst_low_conf", 32'(low_conf), 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed frames with random backpressure.
    rand_rdy = 1'b1;
    send(mk(10, 50, 20, 50, 5));
    send(mk(0, 0, 0, 0, 0));
    send(mk(0, 0, 0, 0, 255));
    send(mk(10, 50, 20, 40, 5));
    send(mk(10, 90, 20, 40, 5));
    send(mk(200, 201, 255, 128, 254));
    drain();

    // Long stall with in_valid pulsing: nothing new may be taken.
    rand_rdy  = 1'b0;
    out_ready = 1'b0;
    send(mk(3, 7, 7, 1, 2));
    g = 0;
    while (!out_valid && g < 50) begin
      tick();
      g++;
    end
    check("stall_result", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      n_in     = FW'({$urandom(), $urandom()});
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    repeat (NUM_IN + 2) tick();

    // Reset two cycles into the scan aborts the frame.
    send(mk(9, 8, 7, 6, 5));
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    tick();
    reset = 1'b0;
    #1;
    check("abort_rel_in_ready", 32'(in_ready), 32'd1);
    send(mk(1, 2, 3, 4, 9));
    drain();

    // Randomized traffic; narrow ranges make ties frequent.
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      bit narrow = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NUM_IN; k++) begin
        f[k*DW +: DW] = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      end
      send(f);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
